ascii_display_scanner: RTL and testbench
========================================

ASCII_DISPLAY_SCANNER -- requirements
Module: ascii_display_scanner

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of multiplexed digits; legal range 2..8.
REQ-002 SHALL have parameter BUF_DEPTH, default 16: message buffer capacity in characters; legal range N_DIGITS+1..32.
REQ-003 SHALL have parameter REFRESH_DIV, default 100000: clock cycles each digit is held active; minimum 2.
REQ-004 SHALL have parameter SCROLL_DIV, default 50000000: clock cycles per scroll step; minimum 2.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wr_valid  input  1  a character is offered on wr_char.
REQ-008 SHALL have port wr_char  input  8  ASCII character to append to the message.
REQ-009 SHALL have port wr_ready  output  1  high when the buffer can accept a character.
REQ-010 SHALL have port clear  input  1  empties the message and resets the scroll position.
REQ-011 SHALL have port scroll_en  input  1  enables scrolling of messages longer than N_DIGITS.
REQ-012 SHALL have port char_out  output  8  ASCII code of the active digit; feeds the ASCII seven-segment decoder val input.
REQ-013 SHALL have port an  output  N_DIGITS  active-low one-hot digit enables.
REQ-014 SHALL have port digit_idx  output  $clog2(N_DIGITS)  index of the active digit; 0 is the rightmost digit.

Function
REQ-015 SHALL hold msg_len (0..BUF_DEPTH) and a BUF_DEPTH x 8 character buffer.
REQ-016 SHALL drive wr_ready = (msg_len < BUF_DEPTH), with no combinational path from any input.
REQ-017 SHALL, when wr_valid && wr_ready && !clear, write wr_char to buffer[msg_len] and increment msg_len.
REQ-018 SHALL, when clear is high, set msg_len and offset to 0, clear the scroll counter, and drop any simultaneous write.
REQ-019 SHALL run a refresh counter 0..REFRESH_DIV-1 continuously; at the terminal count, digit_idx increments, wrapping from N_DIGITS-1 to 0.
REQ-020 SHALL drive an[digit_idx]=0 and every other bit of an to 1.
REQ-021 SHALL give the active digit left-position p = N_DIGITS-1-digit_idx, with p=0 as the leftmost digit.
REQ-022 SHALL drive char_out = 8'h20 (space) when msg_len == 0.
REQ-023 SHALL, when msg_len <= N_DIGITS or scroll_en is low, drive char_out = buffer[p] if p < msg_len, otherwise 8'h20; the message is left-aligned.
REQ-024 SHALL, when scroll_en is high and msg_len > N_DIGITS, drive char_out = buffer[(offset+p) mod msg_len]; the modulo is implemented as a single conditional subtraction.
REQ-025 SHALL run a scroll counter 0..SCROLL_DIV-1 only while scroll_en is high and msg_len > N_DIGITS; at the terminal count, offset increments, wrapping from msg_len-1 to 0.
REQ-026 SHALL hold the scroll counter and offset at 0 whenever scroll_en is low or msg_len <= N_DIGITS.
REQ-027 SHALL keep offset valid when a write occurs during scrolling: offset is unchanged, and the new length applies from the next cycle.
REQ-028 SHALL compute char_out, an and digit_idx combinationally from registered state only, so all three change in the same cycle.
REQ-029 SHALL keep the refresh scan running across clear and writes; only reset restarts it.

Reset
REQ-030 SHALL, while reset is high, set msg_len=0, offset=0, refresh counter=0, scroll counter=0 and digit_idx=0, giving an={N_DIGITS-1{1},0}, char_out=8'h20 and wr_ready=1.
REQ-031 SHALL leave buffer contents unreset; they are unobservable while msg_len=0.
REQ-032 SHALL give reset priority over clear, writes and both counters; reset mid-scroll returns the display to digit 0 showing a space.

Verification
REQ-033 SHALL cover static text: N_DIGITS=8, REFRESH_DIV=4; write "HOLA" -> over 32 cycles digits p0..p3 show 'H','O','L','A' and p4..p7 show 8'h20; each an value is held for 4 cycles.
REQ-034 SHALL cover full buffer: write 16 chars with wr_valid held high -> wr_ready=0 after the 16th accept; a 17th char is not stored and msg_len stays 16.
REQ-035 SHALL cover scrolling: SCROLL_DIV=16, message "0123456789" with scroll_en=1 -> p0 shows '0', then '1' after 16 cycles; after 10 steps offset wraps to 0; p7 with offset=5 shows '2'.
REQ-036 SHALL cover clear colliding with write: clear=1 and wr_valid=1 in the same cycle -> msg_len=0, all digits show 8'h20, and the digit scan is not interrupted.
REQ-037 SHALL cover scroll disable: scroll_en dropped at offset=3 -> the next cycle shows offset 0, left-aligned, first 8 characters.
REQ-038 SHALL cover reset mid-operation: reset asserted at digit_idx=5 with offset=7 -> the next cycle has an=8'hFE, char_out=8'h20, wr_ready=1.

Source files
------------

// File: rtl/ascii_display_scanner.sv
// ASCII message buffer driving a multiplexed digit scan, with optional marquee scrolling.
// Writes append at msg_len; char_out, an and digit_idx are decoded from registered state only.
module ascii_display_scanner #(
  parameter int N_DIGITS    = 8,
  parameter int BUF_DEPTH   = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int SCROLL_DIV  = 50000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_char,
  output logic                        wr_ready,
  input  logic                        clear,
  input  logic                        scroll_en,
  output logic [7:0]                  char_out,
  output logic [N_DIGITS-1:0]         an,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int LEN_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = LEN_W + 1;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int SCR_W = $clog2(SCROLL_DIV);

  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(BUF_DEPTH);
  localparam logic [LEN_W-1:0] NDIG_L   = LEN_W'(N_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_DIV - 1);
  localparam logic [7:0]       SPACE    = 8'h20;

  logic [7:0]       buf_q [BUF_DEPTH];
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic [LEN_W-1:0] offset_q, offset_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [SCR_W-1:0] scr_cnt_q, scr_cnt_d;
  logic [IDX_W-1:0] digit_idx_q, digit_idx_d;

  logic             wr_fire;
  logic             long_msg;
  logic             scroll_run;
  logic [IDX_W-1:0] pos;
  logic [SUM_W-1:0] rd_sum;
  logic [PTR_W-1:0] rd_ptr;

  assign wr_ready   = (msg_len_q < DEPTH_L);
  assign wr_fire    = wr_valid && wr_ready && !clear;
  assign long_msg   = (msg_len_q > NDIG_L);
  assign scroll_run = scroll_en && long_msg;
  assign digit_idx  = digit_idx_q;

  // Next-state for the refresh scan, message length and scroll position.
  always_comb begin
    ref_cnt_d   = ref_cnt_q;
    digit_idx_d = digit_idx_q;
    msg_len_d   = msg_len_q;
    offset_d    = offset_q;
    scr_cnt_d   = scr_cnt_q;

    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      if (digit_idx_q == IDX_LAST) begin
        digit_idx_d = '0;
      end else begin
        digit_idx_d = digit_idx_q + 1'b1;
      end
    end else begin
      ref_cnt_d = ref_cnt_q + 1'b1;
    end

    if (clear) begin
      msg_len_d = '0;
    end else if (wr_fire) begin
      msg_len_d = msg_len_q + 1'b1;
    end else begin
      msg_len_d = msg_len_q;
    end

    // A write only grows msg_len, so an in-flight offset stays below the length.
    if (clear || !scroll_run) begin
      offset_d  = '0;
      scr_cnt_d = '0;
    end else if (scr_cnt_q == SCR_LAST) begin
      scr_cnt_d = '0;
      if (offset_q == msg_len_q - 1'b1) begin
        offset_d = '0;
      end else begin
        offset_d = offset_q + 1'b1;
      end
    end else begin
      scr_cnt_d = scr_cnt_q + 1'b1;
      offset_d  = offset_q;
    end
  end

  // State registers; reset takes precedence over clear, writes and both counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_len_q   <= '0;
      offset_q    <= '0;
      ref_cnt_q   <= '0;
      scr_cnt_q   <= '0;
      digit_idx_q <= '0;
    end else begin
      msg_len_q   <= msg_len_d;
      offset_q    <= offset_d;
      ref_cnt_q   <= ref_cnt_d;
      scr_cnt_q   <= scr_cnt_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  // Character storage is left unreset; entries at or beyond msg_len are never shown.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      buf_q[PTR_W'(msg_len_q)] <= wr_char;
    end
  end

  // Character select. offset is held at 0 outside scrolling, so a long message in static
  // mode takes the same path; offset < len and pos < len make one subtraction a full modulo.
  always_comb begin
    pos    = IDX_LAST - digit_idx_q;
    rd_sum = SUM_W'(offset_q) + SUM_W'(pos);
    if (rd_sum >= SUM_W'(msg_len_q)) begin
      rd_ptr = PTR_W'(rd_sum - SUM_W'(msg_len_q));
    end else begin
      rd_ptr = PTR_W'(rd_sum);
    end

    char_out = SPACE;
    if (msg_len_q == '0) begin
      char_out = SPACE;
    end else if (long_msg) begin
      char_out = buf_q[rd_ptr];
    end else if (LEN_W'(pos) < msg_len_q) begin
      char_out = buf_q[PTR_W'(pos)];
    end else begin
      char_out = SPACE;
    end
  end

  // Active-low one-hot enable for the scanned digit.
  always_comb begin
    an              = '1;
    an[digit_idx_q] = 1'b0;
  end

endmodule

// File: tb/tb_ascii_display_scanner.sv
// Directed bench for ascii_display_scanner: static text, full buffer, clear/write collision,
// scrolling with wrap, scroll disable and reset mid-scroll.
module tb_ascii_display_scanner;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;
  logic       clear;
  logic       scroll_en;
  logic [7:0] char_out;
  logic [7:0] an;
  logic [2:0] digit_idx;

  int         n_chk = 0;
  int         n_bad = 0;
  int         scan_k = 0;
  int         j = 0;
  bit         scroll_m = 1'b0;
  int         len_m = 0;
  logic [7:0] msg_m [32];

  ascii_display_scanner #(
    .N_DIGITS   (8),
    .BUF_DEPTH  (16),
    .REFRESH_DIV(4),
    .SCROLL_DIV (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_char  (wr_char),
    .wr_ready (wr_ready),
    .clear    (clear),
    .scroll_en(scroll_en),
    .char_out (char_out),
    .an       (an),
    .digit_idx(digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; the scan position follows from it alone.
  always @(posedge clk) begin
    if (reset) scan_k <= 0;
    else       scan_k <= scan_k + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_char(input int p);
    int off;
    int k;
    if (len_m == 0) return 8'h20;
    off = scroll_m ? (j / 16) % len_m : 0;
    if (len_m > 8) begin
      k = (off + p) % len_m;
      return msg_m[k[4:0]];
    end
    if (p < len_m) return msg_m[p[4:0]];
    return 8'h20;
  endfunction

  // Advance n cycles, checking the scanned digit, enables and character each cycle.
  task automatic run(input int n);
    logic [7:0] an_e;
    int         idx;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (scroll_m) j++;
      idx  = (scan_k / 4) % 8;
      an_e = ~(8'b1 << idx);
      chk("digit_idx", 32'(digit_idx), idx);
      chk("an", 32'(an), 32'(an_e));
      chk("char_out", 32'(char_out), 32'(exp_char(7 - idx)));
    end
  endtask

  task automatic put(input logic [7:0] c);
    wr_valid = 1'b1;
    wr_char  = c;
    msg_m[len_m[4:0]] = c;
    len_m++;
    run(1);
    wr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_char   = 8'h00;
    clear     = 1'b0;
    scroll_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'h0000_00FE);
    chk("rst_char", 32'(char_out), 32'h0000_0020);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    reset = 1'b0;

    // Static left-aligned text over a full 32-cycle scan.
    put(8'h48); put(8'h4F); put(8'h4C); put(8'h41);
    run(32);

    // Clear and write in the same cycle: write dropped, scan keeps running.
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_char  = 8'h5A;
    len_m    = 0;
    run(1);
    clear    = 1'b0;
    wr_valid = 1'b0;
    chk("clr_ready", 32'(wr_ready), 32'd1);
    run(31);

    // Fill the buffer with wr_valid held; the 17th character is refused.
    wr_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_char = 8'h61 + 8'(i);
      if (len_m < 16) begin
        msg_m[len_m[4:0]] = wr_char;
        len_m++;
      end
      run(1);
      chk("full_ready", 32'(wr_ready), 32'(len_m < 16));
    end
    wr_valid = 1'b0;
    run(32);

    // Scroll "0123456789" through more than one full wrap.
    clear = 1'b1;
    len_m = 0;
    run(1);
    clear = 1'b0;
    for (int i = 0; i < 10; i++) put(8'h30 + 8'(i));
    scroll_en = 1'b1; scroll_m = 1'b1; j = 0;
    run(176);
    scroll_en = 1'b0; scroll_m = 1'b0;
    run(1);

    // Scroll to offset 3, then disable: display returns to left-aligned at once.
    scroll_en = 1'b1; scroll_m = 1'b1; j = 0;
    run(48);
    chk("off3_char", 32'(char_out), 32'(exp_char(7 - 32'(digit_idx))));
    scroll_en = 1'b0; scroll_m = 1'b0;
    run(32);

    // Align so that offset 7 coincides with digit 5, then reset.
    for (int t = 0; t < 32 && (scan_k % 32) != 0; t++) run(1);
    scroll_en = 1'b1; scroll_m = 1'b1; j = 0;
    run(116);
    chk("pre_idx", 32'(digit_idx), 32'd5);
    chk("pre_char", 32'(char_out), 32'h0000_0039);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_an", 32'(an), 32'h0000_00FE);
    chk("mid_char", 32'(char_out), 32'h0000_0020);
    chk("mid_ready", 32'(wr_ready), 32'd1);
    chk("mid_idx", 32'(digit_idx), 32'd0);
    reset     = 1'b0;
    scroll_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
